wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic single-transfer master that issues read and write cycles towards the user project's Wishbone slave port.
- Accepts one command at a time on a valid/ready command channel and drives `cyc`/`stb` until the slave acknowledges.
- Returns read data, or a write completion, on a valid/ready response channel.
- Sits beside the user project inside the wrapper; it replaces the management SoC as the bus initiator for self-test and standalone bring-up of the slave.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of BUS-state cycles to wait for `wbm_ack_i`; legal range 1..65535. Used only with `WB_TIMEOUT_EN`.

Ports:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- `wb_clk_i` in 1: the single clock; all logic is on its rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: a command is present.
- `cmd_ready_o` out 1: the block can accept a command.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in 32: byte address.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: a response is present.
- `rsp_ready_i` in 1: the consumer accepts the response.
- `rsp_dat_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: the transfer timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone cycle, strobe and write-enable.
- `wbm_sel_o` out 4, `wbm_adr_o` out 32, `wbm_dat_o` out 32: Wishbone byte selects, address and write data.
- `wbm_ack_i` in 1, `wbm_dat_i` in 32: slave acknowledge and read data.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- State machine with three states: IDLE, BUS, RESP. All outputs are registered.
- **IDLE**
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i` = 1, latch we/adr/dat/sel into the `wbm_*` registers, set `cyc` = `stb` = 1 and go to BUS.
- **BUS**
  - `cmd_ready_o` = 0.
  - Hold `cyc`, `stb`, `adr`, `dat`, `sel` and `we` stable.
  - On a sampled `wbm_ack_i` = 1: clear `cyc`/`stb`; load `rsp_dat_o` with `wbm_dat_i` for a read or with 0 for a write; set `rsp_err_o` = 0; set `rsp_valid_o` = 1; go to RESP.
- **RESP**
  - Hold `rsp_*` stable while `rsp_ready_i` = 0.
  - On `rsp_ready_i` = 1, clear `rsp_valid_o` and go to IDLE.
  - A new command is accepted no earlier than the cycle after the handshake, so there is at most one outstanding transfer.
- `wbm_ack_i` outside BUS is ignored and causes no state change.
- `wbm_dat_o` holds its last value during reads.
- `cmd_valid_i` arriving while the block is busy waits; the command is not dropped, because the handshake is `valid && ready`.
- Reset, including mid-transfer: every state goes to IDLE on the next edge.
  - `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0.
  - `wbm_sel_o` = 0, `wbm_adr_o` = 0, `wbm_dat_o` = 0.
  - `rsp_valid_o` = 0, `rsp_dat_o` = 0, `rsp_err_o` = 0.
  - `cmd_ready_o` = 1 from the first cycle after reset; `busy_o` = 0.
  - An aborted bus cycle produces no response.

## Timing
- Command handshake at edge N (`cmd_valid_i` && `cmd_ready_o` sampled at N) ⇒ `cyc`/`stb` high from cycle N+1.
- Slave acks in cycle N+k (k ≥ 1) ⇒ `cyc`/`stb` low and `rsp_valid_o` high from cycle N+k+1.
  - A zero-wait-state slave gives a minimum command-to-response latency of 2 cycles.
- Response handshake at edge M ⇒ `cmd_ready_o` high from M+1. The minimum issue interval is 3 cycles with `rsp_ready_i` held at 1.
- `cyc` and `stb` always rise and fall together; no back-to-back cycle keeps `cyc` high.

## Configuration
- Macro: `WB_TIMEOUT_EN`.
- **Defined**
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter equals `TIMEOUT` without an ack, the block drops `cyc`/`stb`, loads `rsp_dat_o` = 32'hDEAD_BEEF, sets `rsp_err_o` = 1 and goes to RESP.
  - An ack in the same cycle as the count match wins: normal response with `rsp_err_o` = 0.
- **Undefined**
  - BUS waits indefinitely for an ack.
  - No counter logic is built; `rsp_err_o` is a constant 0 and `TIMEOUT` is unused.

## Test plan
- **Write, zero-wait slave:** cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF at edge 0 ⇒ `cyc`/`stb`/`we` high in cycle 1 with matching adr/dat/sel; slave acks in cycle 1 ⇒ `rsp_valid_o`=1, `rsp_dat_o`=0, `rsp_err_o`=0 in cycle 2.
- **Read, 3 wait states:** read adr=0x3000_0000; slave returns 0xCAFE_F00D with ack in cycle 4 ⇒ `rsp_dat_o`=0xCAFE_F00D and `rsp_valid_o`=1 in cycle 5; `cyc` stays high for exactly 4 cycles.
- **Response backpressure:** hold `rsp_ready_i`=0 for 5 cycles ⇒ `rsp_*` stable and `cmd_ready_o`=0 throughout; raising `rsp_ready_i` ⇒ `cmd_ready_o`=1 on the next cycle; a pending `cmd_valid_i` is accepted then.
- **Reset mid-BUS:** assert `wb_rst_i` for 1 cycle while `cyc`=1 ⇒ next cycle `cyc`=`stb`=0, `rsp_valid_o`=0, `cmd_ready_o`=1; no response is ever issued for the aborted command.
- **Stray ack:** pulse `wbm_ack_i` in IDLE and in RESP ⇒ no state, output or `rsp_dat_o` change.
- **Timeout (WB_TIMEOUT_EN, TIMEOUT=8), no ack:** ⇒ `cyc` drops after 8 BUS cycles; `rsp_err_o`=1 and `rsp_dat_o`=0xDEAD_BEEF.
- **Timeout boundary (WB_TIMEOUT_EN, TIMEOUT=8):** ack on the count-match cycle ⇒ `rsp_err_o`=0 with the slave's data.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master driven by a valid/ready command/response pair.
// Optional bus timeout is built when WB_TIMEOUT_EN is defined.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CW = 16;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          timeout_hit;

  // Match on the last allowed BUS cycle so cyc stays up for exactly TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d  = cmd_we_i;
          adr_d = cmd_adr_i;
          sel_d = cmd_sel_i;
          // Write data is kept from the last write across reads.
          if (cmd_we_i) dat_d = cmd_dat_i;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef WB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = TIMEOUT_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d       = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
`ifdef WB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
`ifdef WB_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master; timeout cases run when WB_TIMEOUT_EN is defined.
module tb_wb_host_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc;

  wb_host_master #(.TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    wb_rst_i = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_we", 32'(wbm_we_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);

    // Write, zero-wait slave
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    tick();
    cmd_valid_i = 1'b0;
    check("wr_cyc", 32'(wbm_cyc_o), 32'd1);
    check("wr_stb", 32'(wbm_stb_o), 32'd1);
    check("wr_we", 32'(wbm_we_o), 32'd1);
    check("wr_adr", wbm_adr_o, 32'h3000_0004);
    check("wr_dat", wbm_dat_o, 32'hA5A5_1234);
    check("wr_sel", 32'(wbm_sel_o), 32'hF);
    check("wr_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("wr_busy", 32'(busy_o), 32'd1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    tick();
    wbm_ack_i = 1'b0;
    check("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("wr_rsp_dat", rsp_dat_o, 32'd0);
    check("wr_rsp_err", 32'(rsp_err_o), 32'd0);
    check("wr_cyc_low", 32'(wbm_cyc_o), 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("wr_rsp_done", 32'(rsp_valid_o), 32'd0);
    check("wr_idle_ready", 32'(cmd_ready_o), 32'd1);
    check("wr_idle_busy", 32'(busy_o), 32'd0);

    // Read, 3 wait states: ack in cycle 4
    issue(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF);
    n_cyc = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      cmd_valid_i = 1'b0;
      if (wbm_cyc_o) n_cyc++;
      wbm_ack_i = (i == 4);
      wbm_dat_i = (i == 4) ? 32'hCAFE_F00D : 32'h0;
    end
    check("rd_we", 32'(wbm_we_o), 32'd0);
    check("rd_dat_hold", wbm_dat_o, 32'hA5A5_1234);
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    check("rd_cyc_cycles", 32'(n_cyc), 32'd4);
    check("rd_cyc_low", 32'(wbm_cyc_o), 32'd0);
    check("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("rd_rsp_dat", rsp_dat_o, 32'hCAFE_F00D);

    // Backpressure with a pending command and a stray ack in RESP
    issue(1'b1, 32'h3000_0008, 32'h5555_AAAA, 4'h3);
    for (int i = 1; i <= 5; i++) begin
      wbm_ack_i = (i == 2);
      wbm_dat_i = (i == 2) ? 32'h1234_5678 : 32'h0;
      tick();
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_rsp_dat", rsp_dat_o, 32'hCAFE_F00D);
      check("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
      check("bp_cyc", 32'(wbm_cyc_o), 32'd0);
    end
    wbm_ack_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("bp_release_valid", 32'(rsp_valid_o), 32'd0);
    check("bp_release_ready", 32'(cmd_ready_o), 32'd1);
    check("bp_release_cyc", 32'(wbm_cyc_o), 32'd0);
    tick();
    cmd_valid_i = 1'b0;
    check("pend_cyc", 32'(wbm_cyc_o), 32'd1);
    check("pend_adr", wbm_adr_o, 32'h3000_0008);
    check("pend_dat", wbm_dat_o, 32'h5555_AAAA);
    check("pend_sel", 32'(wbm_sel_o), 32'h3);

    // Reset mid-BUS, then stray acks in IDLE produce nothing
    tick();
    check("mid_cyc", 32'(wbm_cyc_o), 32'd1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("abort_cyc", 32'(wbm_cyc_o), 32'd0);
    check("abort_stb", 32'(wbm_stb_o), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("abort_adr", wbm_adr_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wbm_ack_i = (i == 0 || i == 2);
      wbm_dat_i = 32'h9999_0000 + 32'(i);
      tick();
      check("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("idle_rsp_dat", rsp_dat_o, 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_cyc", 32'(wbm_cyc_o), 32'd0);
    end

    // Minimum issue interval: ack and rsp_ready held high
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0BAD_F00D;
    rsp_ready_i = 1'b1;
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h1);
    tick();
    check("ii_cyc1", 32'(wbm_cyc_o), 32'd1);
    tick();
    check("ii_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("ii_rsp_dat", rsp_dat_o, 32'h0BAD_F00D);
    check("ii_cyc_off", 32'(wbm_cyc_o), 32'd0);
    tick();
    check("ii_ready", 32'(cmd_ready_o), 32'd1);
    check("ii_idle_cyc", 32'(wbm_cyc_o), 32'd0);
    tick();
    cmd_valid_i = 1'b0;
    check("ii_cyc2", 32'(wbm_cyc_o), 32'd1);
    tick();
    check("ii_rsp2", 32'(rsp_valid_o), 32'd1);
    tick();
    wbm_ack_i = 1'b0;
    rsp_ready_i = 1'b0;
    check("ii_done", 32'(busy_o), 32'd0);

`ifdef WB_TIMEOUT_EN
    // Timeout, no ack
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    tick();
    cmd_valid_i = 1'b0;
    n_cyc = 0;
    while (wbm_cyc_o && n_cyc < 20) begin
      n_cyc++;
      tick();
    end
    check("to_cyc_cycles", 32'(n_cyc), 32'd8);
    check("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("to_rsp_err", 32'(rsp_err_o), 32'd1);
    check("to_rsp_dat", rsp_dat_o, 32'hDEAD_BEEF);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Ack on the count-match cycle wins
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      cmd_valid_i = 1'b0;
      wbm_ack_i = (i == 8);
      wbm_dat_i = (i == 8) ? 32'h600D_DA7A : 32'h0;
    end
    check("tb_cyc_at8", 32'(wbm_cyc_o), 32'd1);
    tick();
    wbm_ack_i = 1'b0;
    check("tb_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("tb_rsp_err", 32'(rsp_err_o), 32'd0);
    check("tb_rsp_dat", rsp_dat_o, 32'h600D_DA7A);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
